stopwatch_ctrl: RTL and testbench

//  Control stage directly upstream of the 2-digit 30 s BCD down counter. Debounces
//  the START/PAUSE and CLEAR pushbuttons and runs an IDLE/RUN/PAUSE/DONE FSM.

---
 rtl/stopwatch_ctrl.sv | 83 ++++++++
 tb/tb_stopwatch_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced START/PAUSE and CLEAR control FSM for the 30 s BCD down counter.
// Ports: clk, rst_n (async active-low); pb_start/pb_clear raw async buttons;
//        digit1/digit0 counter feedback; en counter enable (RUN only);
//        cnt_clr_n one-cycle active-low counter clear; alarm blinking LED in DONE;
//        state 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
`ifndef BCD_BIT_WIDTH
`define BCD_BIT_WIDTH 4
`endif
`ifndef BCD_ZERO
`define BCD_ZERO 4'd0
`endif
module stopwatch_ctrl #(
  parameter int DB_LEN       = 4,
  parameter int BLINK_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pb_start,
  input  logic                      pb_clear,
  input  logic [`BCD_BIT_WIDTH-1:0] digit1,
  input  logic [`BCD_BIT_WIDTH-1:0] digit0,
  output logic                      en,
  output logic                      cnt_clr_n,
  output logic                      alarm,
  output logic [1:0]                state
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  localparam int BC_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [BC_W-1:0] BC_MAX = BC_W'(BLINK_CYCLES - 1);
  state_t st, nxt;
  logic [1:0] s1, s2, lvl;
  logic [DB_LEN-1:0] sh [2];
  logic [BC_W-1:0] bc;
  logic start_p, clear_p, zero;
  // bit 0 = start, bit 1 = clear; level holds while the window is mixed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      lvl <= '0;
      sh[0] <= '0;
      sh[1] <= '0;
    end else begin
      s1 <= {pb_clear, pb_start};
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        sh[i] <= {sh[i][DB_LEN-2:0], s2[i]};
        lvl[i] <= &sh[i] ? 1'b1 : ~|sh[i] ? 1'b0 : lvl[i];
      end
    end
  // pulse fires on the cycle the window first becomes all ones
  assign start_p = &sh[0] & ~lvl[0];
  assign clear_p = &sh[1] & ~lvl[1];
  assign zero = digit1 == `BCD_ZERO && digit0 == `BCD_ZERO;
  always_comb
    nxt = clear_p      ? IDLE :
          st == IDLE   ? (start_p && !zero ? RUN : IDLE) :
          st == RUN    ? (zero ? DONE : start_p ? PAUSE : RUN) :
          st == PAUSE  ? (start_p ? RUN : PAUSE) : DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      en <= 1'b0;
      cnt_clr_n <= 1'b1;
      alarm <= 1'b0;
      bc <= '0;
    end else begin
      st <= nxt;
      en <= nxt == RUN;
      cnt_clr_n <= ~clear_p;
      if (nxt == DONE && st != DONE) begin
        alarm <= 1'b1;
        bc <= '0;
      end else if (nxt == DONE) begin
        alarm <= bc == BC_MAX ? ~alarm : alarm;
        bc <= bc == BC_MAX ? '0 : bc + 1'b1;
      end else begin
        alarm <= 1'b0;
        bc <= '0;
      end
    end
  assign state = st;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and randomized checks of stopwatch_ctrl against a history-based model.
`ifndef BCD_BIT_WIDTH
`define BCD_BIT_WIDTH 4
`endif
module tb_stopwatch_ctrl;
  localparam int DB = 4;
  localparam int BL = 2;
  logic clk = 0, rst_n = 0, pb_start = 0, pb_clear = 0;
  logic [`BCD_BIT_WIDTH-1:0] digit1 = 4'd2, digit0 = 4'd7;
  logic en, cnt_clr_n, alarm;
  logic [1:0] state;
  int vectors = 0, miscompares = 0;
  int st_m, age;
  bit en_m, clr_m, al_m, lvl_s, lvl_c;
  bit hs[$], hc[$];
  stopwatch_ctrl #(.DB_LEN(DB), .BLINK_CYCLES(BL)) dut (
    .clk(clk), .rst_n(rst_n), .pb_start(pb_start), .pb_clear(pb_clear),
    .digit1(digit1), .digit0(digit0), .en(en), .cnt_clr_n(cnt_clr_n),
    .alarm(alarm), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    st_m = 0; age = 0; en_m = 0; clr_m = 1; al_m = 0; lvl_s = 0; lvl_c = 0;
    hs.delete(); hc.delete();
    for (int i = 0; i < DB + 2; i++) begin hs.push_back(0); hc.push_back(0); end
  endtask
  // raw history, newest first: entries 2..DB+1 are the debounce window
  task automatic model_edge();
    bit a1s = 1, a0s = 1, a1c = 1, a0c = 1, sp, cp, z;
    int ns;
    for (int i = 2; i < DB + 2; i++) begin
      a1s &= hs[i]; a0s &= !hs[i]; a1c &= hc[i]; a0c &= !hc[i];
    end
    sp = a1s && !lvl_s;
    cp = a1c && !lvl_c;
    lvl_s = a1s ? 1 : a0s ? 0 : lvl_s;
    lvl_c = a1c ? 1 : a0c ? 0 : lvl_c;
    hs.push_front(pb_start); void'(hs.pop_back());
    hc.push_front(pb_clear); void'(hc.pop_back());
    z = digit1 == 0 && digit0 == 0;
    if (cp) ns = 0;
    else case (st_m)
      0: ns = (sp && !z) ? 1 : 0;
      1: ns = z ? 3 : sp ? 2 : 1;
      2: ns = sp ? 1 : 2;
      default: ns = 3;
    endcase
    age = (ns == 3 && st_m == 3) ? age + 1 : 0;
    st_m = ns;
    en_m = ns == 1;
    clr_m = !cp;
    al_m = ns == 3 && ((age / BL) % 2 == 0);
  endtask
  task automatic check_all();
    chk("state", state, 2'(st_m));
    chk("en", {1'b0, en}, {1'b0, en_m});
    chk("cnt_clr_n", {1'b0, cnt_clr_n}, {1'b0, clr_m});
    chk("alarm", {1'b0, alarm}, {1'b0, al_m});
  endtask
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (!rst_n) model_reset(); else model_edge();
      #1;
      check_all();
      vectors++;
    end
  endtask
  // asserts reset mid-cycle and checks outputs clear without waiting for an edge
  task automatic do_reset(int n);
    #2 rst_n = 0;
    #1 model_reset();
    check_all();
    vectors++;
    step(n);
    rst_n = 1;
  endtask
  task automatic press(bit s, bit c);
    pb_start = s; pb_clear = c;
    step(DB + 3);
    pb_start = 0; pb_clear = 0;
    step(DB + 3);
  endtask
  logic exp_al [6] = '{1, 1, 0, 0, 1, 1};
  initial begin
    model_reset();
    // T1 reset
    step(3);
    chk("t1_state", state, 2'b00);
    chk("t1_clr", {1'b0, cnt_clr_n}, 2'd1);
    rst_n = 1;
    step(2);
    // T2 bounce then stable press
    pb_start = 1; step(); pb_start = 0; step(); pb_start = 1; step(); pb_start = 0; step();
    pb_start = 1;
    step(DB + 2);
    chk("t2_before", state, 2'b00);
    step();
    chk("t2_run", state, 2'b01);
    chk("t2_en", {1'b0, en}, 2'd1);
    step(3);
    pb_start = 0;
    step(DB + 3);
    // T3 pause/resume
    press(1, 0);
    chk("t3_pause", state, 2'b10);
    chk("t3_en", {1'b0, en}, 2'd0);
    press(1, 0);
    chk("t3_resume", state, 2'b01);
    // T4 terminal count and alarm blink
    digit1 = 0; digit0 = 1; step();
    digit0 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t4_alarm", {1'b0, alarm}, {1'b0, exp_al[i]});
    end
    chk("t4_done", state, 2'b11);
    // T5 start ignored in DONE, clear exits with alarm off
    press(1, 0);
    chk("t5_done_hold", state, 2'b11);
    pb_clear = 1;
    step(DB + 3);
    chk("t5_idle", state, 2'b00);
    chk("t5_alarm", {1'b0, alarm}, 2'd0);
    chk("t5_clr_lo", {1'b0, cnt_clr_n}, 2'd0);
    step();
    chk("t5_clr_hi", {1'b0, cnt_clr_n}, 2'd1);
    pb_clear = 0;
    step(DB + 3);
    digit1 = 2; digit0 = 7;
    press(1, 0);
    chk("t5_run", state, 2'b01);
    pb_start = 1; pb_clear = 1;
    step(DB + 3);
    chk("t5_prio", state, 2'b00);
    chk("t5_prio_clr", {1'b0, cnt_clr_n}, 2'd0);
    step();
    chk("t5_prio_clr1", {1'b0, cnt_clr_n}, 2'd1);
    pb_start = 0; pb_clear = 0;
    step(DB + 3);
    // T6 zero in IDLE
    digit1 = 0; digit0 = 0;
    press(1, 0);
    chk("t6_idle", state, 2'b00);
    // mid-operation reset discards partial debounce
    digit1 = 1; digit0 = 5;
    press(1, 0);
    chk("rst_run", state, 2'b01);
    pb_start = 1;
    step(DB);
    do_reset(2);
    step(4);
    chk("rst_idle", state, 2'b00);
    pb_start = 0;
    step(DB + 3);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(9) == 0) pb_start = ~pb_start;
      if ($urandom_range(29) == 0) pb_clear = ~pb_clear;
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: begin digit1 = 0; digit0 = 0; end
          1: begin digit1 = 0; digit0 = 1; end
          default: begin digit1 = 4'($urandom_range(2)); digit0 = 4'($urandom_range(9)); end
        endcase
      end
      if ($urandom_range(399) == 0) do_reset(1);
      else step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
